// File: rtl/hls_pkg.sv
// Shared types and helpers for the HLS dot-product operator:
// FSM state encoding and the clog2 used to size the pair index.
package hls_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } hls_state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x != 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hls_mac_unit.sv
// Combinational multiply-accumulate step: {carry, sum} = acc + a*b.
// The add is performed at RES_W+1 bits so the carry exposes overflow.
module hls_mac_unit #(
  parameter int unsigned ARG_W = 8,
  parameter int unsigned RES_W = 16
) (
  input  logic [RES_W-1:0] acc,
  input  logic [ARG_W-1:0] a,
  input  logic [ARG_W-1:0] b,
  output logic             carry_c,
  output logic [RES_W-1:0] sum_c
);

  localparam int unsigned PROD_W = 2 * ARG_W;
  localparam int unsigned SUM_W  = RES_W + 1;

  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  total;

  assign prod             = PROD_W'(a) * PROD_W'(b);
  assign total            = SUM_W'(acc) + SUM_W'(prod);
  assign {carry_c, sum_c} = total;

endmodule

// File: rtl/hls_dot_eval.sv
// Multi-cycle HLS operator: return_val = bias + sum(a[i]*b[i]), one MAC per cycle.
// Optional macro HLS_DOT_SAT_EN: accumulator saturates once overflow is seen.
module hls_dot_eval
  import hls_pkg::*;
#(
  parameter int unsigned ARG_W     = 8,
  parameter int unsigned NUM_PAIRS = 4,
  parameter int unsigned RES_W     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       finish,
  input  logic [NUM_PAIRS*ARG_W-1:0] arg_a,
  input  logic [NUM_PAIRS*ARG_W-1:0] arg_b,
  input  logic [RES_W-1:0]           bias,
  output logic [RES_W-1:0]           return_val,
  output logic                       ovf
);

  localparam int unsigned OPS_W = NUM_PAIRS * ARG_W;
  localparam int unsigned IDX_W = (NUM_PAIRS > 1) ? clog2(NUM_PAIRS) : 1;

  hls_state_t       state_q, state_d;
  logic [OPS_W-1:0] a_q, a_d, b_q, b_d;
  logic [RES_W-1:0] acc_q, acc_d, ret_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovf_int_q, ovf_int_d, ovf_d;

  logic [ARG_W-1:0] a_cur, b_cur;
  logic             mac_carry;
  logic [RES_W-1:0] mac_sum;

  assign a_cur = a_q[32'(idx_q) * ARG_W +: ARG_W];
  assign b_cur = b_q[32'(idx_q) * ARG_W +: ARG_W];

  hls_mac_unit #(
    .ARG_W(ARG_W),
    .RES_W(RES_W)
  ) u_mac (
    .acc    (acc_q),
    .a      (a_cur),
    .b      (b_cur),
    .carry_c(mac_carry),
    .sum_c  (mac_sum)
  );

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    ovf_int_d = ovf_int_q;
    ret_d     = return_val;
    ovf_d     = ovf;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d       = arg_a;
          b_d       = arg_b;
          acc_d     = bias;
          idx_d     = '0;
          ovf_int_d = 1'b0;
          state_d   = ST_CALC;
        end
      end
      ST_CALC: begin
        ovf_int_d = ovf_int_q | mac_carry;
`ifdef HLS_DOT_SAT_EN
        acc_d     = ovf_int_d ? '1 : mac_sum;
`else
        acc_d     = mac_sum;
`endif
        idx_d     = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_PAIRS - 1)) begin
          ret_d   = acc_d;
          ovf_d   = ovf_int_d;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any call in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      ovf_int_q  <= 1'b0;
      return_val <= '0;
      ovf        <= 1'b0;
      busy       <= 1'b0;
      finish     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      ovf_int_q  <= ovf_int_d;
      return_val <= ret_d;
      ovf        <= ovf_d;
      busy       <= (state_d != ST_IDLE);
      finish     <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_hls_dot_eval.sv
// Directed self-checking bench for hls_dot_eval: default build plus
// NUM_PAIRS=1 and NUM_PAIRS=8 instances (ARG_W=4, RES_W=12).
module tb_hls_dot_eval;

`ifdef HLS_DOT_SAT_EN
  localparam logic [31:0] OVF_RET0 = 32'd65535;
  localparam logic [31:0] OVF_RET1 = 32'd4095;
  localparam logic [31:0] OVF_RET8 = 32'd4095;
`else
  localparam logic [31:0] OVF_RET0 = 32'd63492;
  localparam logic [31:0] OVF_RET1 = 32'd129;
  localparam logic [31:0] OVF_RET8 = 32'd704;
`endif

  logic        clk = 1'b0;
  logic        reset;

  logic        start0, busy0, finish0, ovf0;
  logic [31:0] a0, b0;
  logic [15:0] bias0, ret0;

  logic        start1, busy1, finish1, ovf1;
  logic [3:0]  a1, b1;
  logic [11:0] bias1, ret1;

  logic        start8, busy8, finish8, ovf8;
  logic [31:0] a8, b8;
  logic [11:0] bias8, ret8;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hls_dot_eval u_dut (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .finish(finish0),
    .arg_a(a0), .arg_b(b0), .bias(bias0), .return_val(ret0), .ovf(ovf0)
  );

  hls_dot_eval #(.ARG_W(4), .NUM_PAIRS(1), .RES_W(12)) u_p1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .finish(finish1),
    .arg_a(a1), .arg_b(b1), .bias(bias1), .return_val(ret1), .ovf(ovf1)
  );

  hls_dot_eval #(.ARG_W(4), .NUM_PAIRS(8), .RES_W(12)) u_p8 (
    .clk(clk), .reset(reset), .start(start8), .busy(busy8), .finish(finish8),
    .arg_a(a8), .arg_b(b8), .bias(bias8), .return_val(ret8), .ovf(ovf8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  function automatic logic get_fin(input int sel);
    case (sel)
      0:       return finish0;
      1:       return finish1;
      default: return finish8;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy0;
      1:       return busy1;
      default: return busy8;
    endcase
  endfunction

  function automatic logic get_ovf(input int sel);
    case (sel)
      0:       return ovf0;
      1:       return ovf1;
      default: return ovf8;
    endcase
  endfunction

  function automatic logic [31:0] get_ret(input int sel);
    case (sel)
      0:       return 32'(ret0);
      1:       return 32'(ret1);
      default: return 32'(ret8);
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start0 = v;
      1:       start1 = v;
      default: start8 = v;
    endcase
  endtask

  task automatic load(input int sel, input logic [31:0] a_pk, input logic [31:0] b_pk,
                      input logic [31:0] bias_v);
    case (sel)
      0:       begin a0 = a_pk;     b0 = b_pk;     bias0 = 16'(bias_v); end
      1:       begin a1 = 4'(a_pk); b1 = 4'(b_pk); bias1 = 12'(bias_v); end
      default: begin a8 = a_pk;     b8 = b_pk;     bias8 = 12'(bias_v); end
    endcase
  endtask

  // Wait (bounded) for finish; checks latency from edge T, result, flag
  task automatic wait_done(input int sel, input int np, input logic [31:0] exp_ret,
                           input logic exp_ovf, input string tag);
    int k;
    k = 0;
    while (!get_fin(sel) && k < 50) begin
      tick();
      k++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(np));
    chk({tag, "_ret"}, get_ret(sel), exp_ret);
    chk({tag, "_ovf"}, 32'(get_ovf(sel)), 32'(exp_ovf));
    tick();
    chk({tag, "_pulse"}, 32'(get_fin(sel)), 32'd0);
    chk({tag, "_idle"}, 32'(get_busy(sel)), 32'd0);
  endtask

  task automatic call(input int sel, input logic [31:0] a_pk, input logic [31:0] b_pk,
                      input logic [31:0] bias_v, input int np, input logic [31:0] exp_ret,
                      input logic exp_ovf, input string tag);
    load(sel, a_pk, b_pk, bias_v);
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    chk({tag, "_busy"}, 32'(get_busy(sel)), 32'd1);
    wait_done(sel, np, exp_ret, exp_ovf, tag);
  endtask

  initial begin
    reset  = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start8 = 1'b0;
    a0 = '0; b0 = '0; bias0 = '0;
    a1 = '0; b1 = '0; bias1 = '0;
    a8 = '0; b8 = '0; bias8 = '0;
    tick();
    tick();
    chk("rst_ret", 32'(ret0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_fin", 32'(finish0), 32'd0);
    reset = 1'b1;
    tick();

    // Basic: 5*9 + 12*1 + 4*3 + 2*7 + 10 = 93
    call(0, 32'h02_04_0C_05, 32'h07_03_01_09, 32'd10, 4, 32'd93, 1'b0, "basic");

    // Overflow: 4*255*255 wraps to 63492 (or clamps to 65535)
    call(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4, OVF_RET0, 1'b1, "ovf");

    // Input hold; previous result and flag are held until DONE
    load(0, 32'h02_04_0C_05, 32'h07_03_01_09, 32'd10);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("hold_prev_ret", 32'(ret0), OVF_RET0);
    chk("hold_prev_ovf", 32'(ovf0), 32'd1);
    a0 = 32'hFFFF_FFFF;
    bias0 = 16'd1000;
    wait_done(0, 4, 32'd93, 1'b0, "hold");

    // Start held high: one call, then a second starting after DONE
    load(0, 32'h01_01_01_01, 32'h01_02_03_04, 32'd0);
    start0 = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_nofin", 32'(finish0), 32'd0);
    end
    tick();
    chk("busy_fin", 32'(finish0), 32'd1);
    chk("busy_ret", 32'(ret0), 32'd10);
    tick();
    chk("busy_done_idle", 32'(busy0), 32'd0);
    chk("busy_done_fin", 32'(finish0), 32'd0);
    tick();
    chk("busy_second", 32'(busy0), 32'd1);
    start0 = 1'b0;
    b0 = 32'h02_02_02_02;
    wait_done(0, 4, 32'd10, 1'b0, "busy2");

    // Reset mid-CALC at idx=2, then a clean call
    load(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #2;
    chk("mrst_ret", 32'(ret0), 32'd0);
    chk("mrst_busy", 32'(busy0), 32'd0);
    chk("mrst_fin", 32'(finish0), 32'd0);
    #1;
    reset = 1'b1;
    tick();
    tick();
    chk("mrst_stay_idle", 32'(busy0), 32'd0);
    chk("mrst_no_fin", 32'(finish0), 32'd0);
    call(0, 32'h02_04_0C_05, 32'h07_03_01_09, 32'd10, 4, 32'd93, 1'b0, "after_rst");

    // Parameter sweep
    call(1, 32'hF, 32'hF, 32'd100, 1, 32'd325, 1'b0, "p1");
    call(1, 32'hF, 32'hF, 32'd4000, 1, OVF_RET1, 1'b1, "p1_ovf");
    call(2, 32'h8765_4321, 32'h1234_5678, 32'd5, 8, 32'd125, 1'b0, "p8");
    call(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3000, 8, OVF_RET8, 1'b1, "p8_ovf");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
